// File: rtl/load_store_unit.sv
// Load/store unit: executes decoded memory requests on a word-wide data bus.
// Build option LSU_MISALIGN_TRAP_EN: misaligned requests are reported instead of force-aligned.
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [1:0]        req_len,
   input  logic              req_sign,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_misalign,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ADDR, WAIT_R, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [1:0]        len_q, len_d;
   logic              sign_q, sign_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
   logic              misalign_q, misalign_d;
   logic              req_misalign;
`endif

   logic              accept;
   logic              has_access;
   logic              capture;
   logic [1:0]        req_off;
   logic [3:0]        req_wstrb;
   logic [31:0]       req_wdata_rep;

   // Lane extraction plus sign/zero extension of a returned bus word.
   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] len,
                                           input logic sign, input logic [1:0] off);
      logic [31:0] byte_sh;
      logic [31:0] half_sh;
      byte_sh = word >> {off, 3'b000};
      half_sh = word >> {off[1], 4'b0000};
      if (len[1])
         return word;
      else if (len[0])
         return {{16{sign & half_sh[15]}}, half_sh[15:0]};
      else
         return {{24{sign & byte_sh[7]}}, byte_sh[7:0]};
   endfunction

   assign accept     = req_valid & req_ready;
   assign has_access = req_load | req_store;
   assign capture    = ~mem_we_q & mem_rvalid &
                       (((state_q == ADDR) & mem_ready) | (state_q == WAIT_R));

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_misalign = (req_len == 2'b01 & req_addr[0]) | (req_len[1] & (|req_addr[1:0]));
`endif

   // Misaligned offsets collapse onto the containing aligned half/word.
   always_comb begin
      if (req_len[1])
         req_off = 2'b00;
      else if (req_len[0])
         req_off = {req_addr[1], 1'b0};
      else
         req_off = req_addr[1:0];
   end

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      req_wstrb     = 4'b0000;
      req_wdata_rep = req_wdata;
      if (req_len == 2'b01)
         req_wdata_rep = {2{req_wdata[15:0]}};
      else if (req_len == 2'b00)
         req_wdata_rep = {4{req_wdata[7:0]}};
      if (req_store) begin
         if (req_len[1])
            req_wstrb = 4'b1111;
         else if (req_len[0])
            req_wstrb = 4'b0011 << req_off;
         else
            req_wstrb = 4'b0001 << req_off;
      end
   end

   // Request latch and load-data capture.
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      len_d       = len_q;
      sign_d      = sign_q;
      off_d       = off_q;
      rdata_d     = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_d  = misalign_q;
`endif
      if (accept) begin
         mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
         mem_we_d    = req_store;
         mem_wstrb_d = req_wstrb;
         mem_wdata_d = req_wdata_rep;
         len_d       = req_len;
         sign_d      = req_sign;
         off_d       = req_off;
         if (!has_access)
            rdata_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_d  = has_access & req_misalign;
`endif
      end
      if (capture)
         rdata_d = extract(mem_rdata, len_q, sign_q, off_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         // NOTE: sequential state uses non-blocking assignment so all flops sample together.
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:
            if (accept) begin
               if (!has_access)
                  state_d = RESP;
`ifdef LSU_MISALIGN_TRAP_EN
               else if (req_misalign)
                  state_d = RESP;
`endif
               else
                  state_d = ADDR;
            end
         ADDR:
            if (mem_ready)
               state_d = (mem_we_q || mem_rvalid) ? RESP : WAIT_R;
         WAIT_R:
            if (mem_rvalid)
               state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      mem_valid = (state_q == ADDR);
      rsp_valid = (state_q == RESP);
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_misalign = (state_q == RESP) & misalign_q;
`else
      rsp_misalign = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wstrb_q <= 4'b0000;
         mem_wdata_q <= '0;
         len_q       <= 2'b00;
         sign_q      <= 1'b0;
         off_q       <= 2'b00;
         rdata_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         len_q       <= len_d;
         sign_q      <= sign_d;
         off_q       <= off_d;
         rdata_q     <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_q  <= misalign_d;
`endif
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wstrb = mem_wstrb_q;
   assign mem_wdata = mem_wdata_q;
   assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized traffic against a byte-level model.
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it.
module tb_load_store_unit;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_load, req_store, req_sign;
   logic [1:0]        req_len;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid, rsp_misalign;
   logic [31:0]       rsp_rdata;
   logic              mem_valid, mem_ready, mem_we, mem_rvalid;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_last;

   logic        obs_bus, obs_we, obs_stable, obs_late_bus, obs_mis, obs_one, obs_idle;
   logic [31:0] obs_addr, obs_wdata, obs_rdata;
   logic [3:0]  obs_wstrb;
   int          obs_rsp_cyc;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
      .req_len(req_len), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   // ---------------- reference model (byte-size arithmetic) ----------------
   function automatic int size_of(input logic [1:0] len);
      return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
   endfunction

   function automatic int model_off(input logic [1:0] len, input logic [31:0] addr);
      int sz;
      sz = size_of(len);
      return ((int'(addr % 4)) / sz) * sz;
   endfunction

   function automatic logic [3:0] model_strobe(input logic [1:0] len, input logic [31:0] addr);
      int s;
      s = ((1 << size_of(len)) - 1) << model_off(len, addr);
      return s[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] len, input logic [31:0] wd);
      case (size_of(len))
         1:       return (wd & 32'h0000_00FF) * 32'h0101_0101;
         2:       return (wd & 32'h0000_FFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] len, input logic sg,
                                              input logic [31:0] addr, input logic [31:0] word);
      longint v;
      int     sz;
      sz = size_of(len);
      v  = longint'(word) >> (8 * model_off(len, addr));
      if (sz < 4) begin
         v = v % (longint'(1) << (8 * sz));
         if (sg && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
      end
      return v[31:0];
   endfunction

   // ---------------- bus driver: one request, bus responder, response capture ----------------
   task automatic run_txn(input logic ld, input logic st, input logic [1:0] len, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int rdy_dly, input int rv_dly, input logic [31:0] rword);
      int   waited;
      int   rv_cnt;
      logic hs_done;
      obs_bus = 0; obs_stable = 1; obs_late_bus = 0; obs_rsp_cyc = -1;
      obs_rdata = '0; obs_mis = 0; obs_one = 0; obs_idle = 0;
      obs_addr = '0; obs_we = 0; obs_wstrb = '0; obs_wdata = '0;
      @(negedge clk);
      for (int i = 0; i < 16 && !req_ready; i++) @(negedge clk);
      req_valid = 1; req_load = ld; req_store = st; req_len = len; req_sign = sg;
      req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 0; req_load = 1'($urandom); req_store = 1'($urandom); req_len = 2'($urandom);
      req_sign = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      waited = 0; rv_cnt = -1; hs_done = 0;
      for (int c = 1; c <= 64; c++) begin
         mem_ready = 0; mem_rvalid = 0; mem_rdata = $urandom;
         if (rsp_valid) begin
            obs_rsp_cyc = c; obs_rdata = rsp_rdata; obs_mis = rsp_misalign;
            break;
         end
         if (mem_valid) begin
            if (hs_done)
               obs_late_bus = 1;
            else if (!obs_bus) begin
               obs_bus = 1; obs_addr = mem_addr; obs_we = mem_we;
               obs_wstrb = mem_wstrb; obs_wdata = mem_wdata;
            end else if (mem_addr !== obs_addr || mem_we !== obs_we ||
                         mem_wstrb !== obs_wstrb || mem_wdata !== obs_wdata)
               obs_stable = 0;
            if (!hs_done && waited >= rdy_dly) begin
               mem_ready = 1; hs_done = 1;
               if (ld && !st) rv_cnt = rv_dly;
            end else
               mem_rvalid = 1'($urandom);   // stray read-valid during a stall
            waited++;
         end
         if (rv_cnt == 0) begin
            mem_rvalid = 1; mem_rdata = rword;
         end
         if (rv_cnt >= 0) rv_cnt--;
         @(negedge clk);
      end
      mem_ready = 0; mem_rvalid = 0;
      @(negedge clk);
      obs_one  = !rsp_valid;
      obs_idle = req_ready;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, mem_valid, mem_we, mem_wstrb, rsp_valid, rsp_misalign} !== 9'b1_0_0_0000_0_0) begin
         errors++;
         $display("FAIL reset_ctrl got %b expected %b",
                  {req_ready, mem_valid, mem_we, mem_wstrb, rsp_valid, rsp_misalign}, 9'b100000000);
      end
      checks++;
      if ({rsp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h expected zeros", rsp_rdata, mem_addr, mem_wdata);
      end
      rst_n = 1;
      exp_last = '0;
   endtask

   task automatic test_word_store();
      run_txn(0, 1, 2'd2, 0, 32'h104, 32'hDEAD_BEEF, 0, 0, 32'h0);
      checks++; if (obs_addr !== 32'h104) begin errors++; $display("FAIL sw_addr got %h expected %h", obs_addr, 32'h104); end
      checks++; if (obs_wstrb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb got %b expected 1111", obs_wstrb); end
      checks++; if (obs_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got %h expected deadbeef", obs_wdata); end
      checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL sw_we got %b expected 1", obs_we); end
      checks++; if (obs_rsp_cyc != 2) begin errors++; $display("FAIL sw_latency got %0d expected 2", obs_rsp_cyc); end
      checks++; if (obs_rdata !== exp_last) begin errors++; $display("FAIL sw_rdata_hold got %h expected %h", obs_rdata, exp_last); end
   endtask

   task automatic test_byte_store();
      run_txn(0, 1, 2'd0, 0, 32'h23, 32'h0000_00A5, 1, 0, 32'h0);
      checks++; if (obs_addr !== 32'h20) begin errors++; $display("FAIL sb_addr got %h expected 20", obs_addr); end
      checks++; if (obs_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got %b expected 1000", obs_wstrb); end
      checks++; if (obs_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h expected a5a5a5a5", obs_wdata); end
      checks++; if (obs_rsp_cyc != 3) begin errors++; $display("FAIL sb_latency got %0d expected 3", obs_rsp_cyc); end
   endtask

   task automatic test_load_byte();
      run_txn(1, 0, 2'd0, 1, 32'h11, 32'h0, 0, 3, 32'h1234_8056);
      checks++; if (obs_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h expected ffffff80", obs_rdata); end
      checks++; if (obs_rsp_cyc != 5) begin errors++; $display("FAIL lb_latency got %0d expected 5", obs_rsp_cyc); end
      checks++; if (obs_one !== 1'b1) begin errors++; $display("FAIL lb_pulse got %b expected 1", obs_one); end
      checks++; if (obs_wstrb !== 4'b0000) begin errors++; $display("FAIL lb_wstrb got %b expected 0000", obs_wstrb); end
      run_txn(1, 0, 2'd0, 0, 32'h11, 32'h0, 0, 3, 32'h1234_8056);
      checks++; if (obs_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h expected 00000080", obs_rdata); end
      exp_last = 32'h0000_0080;
   endtask

   task automatic test_load_half();
      run_txn(1, 0, 2'd1, 1, 32'h2, 32'h0, 4, 1, 32'h9ABC_0000);
      checks++; if (obs_rdata !== 32'hFFFF_9ABC) begin errors++; $display("FAIL lh_data got %h expected ffff9abc", obs_rdata); end
      checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL lh_stall_stable got %b expected 1", obs_stable); end
      checks++; if (obs_addr !== 32'h0) begin errors++; $display("FAIL lh_addr got %h expected 0", obs_addr); end
      checks++; if (obs_rsp_cyc != 7) begin errors++; $display("FAIL lh_latency got %0d expected 7", obs_rsp_cyc); end
      run_txn(1, 0, 2'd1, 0, 32'h2, 32'h0, 4, 1, 32'h9ABC_0000);
      checks++; if (obs_rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_data got %h expected 00009abc", obs_rdata); end
      exp_last = 32'h0000_9ABC;
   endtask

   task automatic test_misaligned();
      run_txn(1, 0, 2'd2, 0, 32'h6, 32'h0, 0, 0, 32'h1122_3344);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++; if (obs_bus !== 1'b0) begin errors++; $display("FAIL mis_no_bus got %b expected 0", obs_bus); end
      checks++; if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_flag got %b expected 1", obs_mis); end
      checks++; if (obs_rsp_cyc != 1) begin errors++; $display("FAIL mis_latency got %0d expected 1", obs_rsp_cyc); end
      checks++; if (obs_rdata !== exp_last) begin errors++; $display("FAIL mis_rdata got %h expected %h", obs_rdata, exp_last); end
`else
      checks++; if (obs_addr !== 32'h4) begin errors++; $display("FAIL mis_addr got %h expected 4", obs_addr); end
      checks++; if (obs_mis !== 1'b0) begin errors++; $display("FAIL mis_flag got %b expected 0", obs_mis); end
      checks++; if (obs_rdata !== 32'h1122_3344) begin errors++; $display("FAIL mis_rdata got %h expected 11223344", obs_rdata); end
      exp_last = 32'h1122_3344;
`endif
   endtask

   task automatic test_noop_and_both();
      run_txn(0, 0, 2'd2, 0, 32'h80, 32'h0, 0, 0, 32'h0);
      checks++; if (obs_bus !== 1'b0) begin errors++; $display("FAIL noop_bus got %b expected 0", obs_bus); end
      checks++; if (obs_rsp_cyc != 1) begin errors++; $display("FAIL noop_latency got %0d expected 1", obs_rsp_cyc); end
      checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL noop_rdata got %h expected 0", obs_rdata); end
      exp_last = 32'h0;
      run_txn(1, 1, 2'd1, 0, 32'h46, 32'h0000_C3D2, 0, 0, 32'hFFFF_FFFF);
      checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL both_we got %b expected 1", obs_we); end
      checks++; if (obs_wstrb !== 4'b1100) begin errors++; $display("FAIL both_wstrb got %b expected 1100", obs_wstrb); end
      checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL both_rdata got %h expected 0", obs_rdata); end
   endtask

   task automatic test_reset_mid_txn();
      int seen;
      @(negedge clk);
      req_valid = 1; req_load = 1; req_store = 0; req_len = 2'd2; req_sign = 0;
      req_addr = 32'h40; req_wdata = 32'h0;
      @(negedge clk);
      req_valid = 0; mem_ready = 1;
      @(negedge clk);
      mem_ready = 0;
      checks++; if ({mem_valid, rsp_valid} !== 2'b00) begin errors++; $display("FAIL wait_r_idle_bus got %b expected 00", {mem_valid, rsp_valid}); end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({req_ready, mem_valid, mem_we, mem_wstrb, rsp_valid, rsp_misalign} !== 9'b1_0_0_0000_0_0) begin
         errors++;
         $display("FAIL midrst_ctrl got %b expected 100000000",
                  {req_ready, mem_valid, mem_we, mem_wstrb, rsp_valid, rsp_misalign});
      end
      checks++;
      if ({rsp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
         errors++;
         $display("FAIL midrst_data got %h %h %h expected zeros", rsp_rdata, mem_addr, mem_wdata);
      end
      @(negedge clk);
      rst_n = 1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1; mem_rdata = $urandom;
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      mem_rvalid = 0;
      checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stray_rsp got %0d expected 0", seen); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b expected 1", req_ready); end
      exp_last = '0;
   endtask

   task automatic test_random_back_to_back();
      for (int n = 0; n < 60; n++) begin
         logic        ld, st, sg, acc, is_ld, mis, e_bus, e_mis;
         logic [1:0]  len;
         logic [31:0] addr, wd, rw, e_rdata;
         int          rd, vd, k, e_cyc;
         k  = $urandom_range(0, 9);
         ld = (k == 1) || (k >= 6);
         st = (k >= 1) && (k <= 5);
         len = 2'($urandom); sg = 1'($urandom);
         addr = $urandom; wd = $urandom; rw = $urandom;
         rd = $urandom_range(0, 3); vd = $urandom_range(0, 3);
         run_txn(ld, st, len, sg, addr, wd, rd, vd, rw);

         acc   = ld | st;
         is_ld = ld & !st;
         mis   = acc && ((addr % size_of(len)) != 0);
`ifndef LSU_MISALIGN_TRAP_EN
         mis = 1'b0;
`endif
         if (!acc) begin
            e_bus = 0; e_cyc = 1; e_rdata = 32'h0; e_mis = 0;
         end else if (mis) begin
            e_bus = 0; e_cyc = 1; e_rdata = exp_last; e_mis = 1;
         end else begin
            e_bus = 1; e_cyc = 2 + rd + (is_ld ? vd : 0); e_mis = 0;
            e_rdata = is_ld ? model_load(len, sg, addr, rw) : exp_last;
         end
         exp_last = e_rdata;

         checks++; if (obs_rsp_cyc != e_cyc) begin errors++; $display("FAIL rnd%0d latency got %0d expected %0d", n, obs_rsp_cyc, e_cyc); end
         checks++; if (obs_rdata !== e_rdata) begin errors++; $display("FAIL rnd%0d rdata got %h expected %h", n, obs_rdata, e_rdata); end
         checks++; if (obs_mis !== e_mis) begin errors++; $display("FAIL rnd%0d misalign got %b expected %b", n, obs_mis, e_mis); end
         checks++; if ({obs_one, obs_idle} !== 2'b11) begin errors++; $display("FAIL rnd%0d pulse_idle got %b expected 11", n, {obs_one, obs_idle}); end
         checks++; if (obs_bus !== e_bus) begin errors++; $display("FAIL rnd%0d bus_used got %b expected %b", n, obs_bus, e_bus); end
         if (e_bus) begin
            checks++; if (obs_addr !== (addr & ~32'h3)) begin errors++; $display("FAIL rnd%0d addr got %h expected %h", n, obs_addr, addr & ~32'h3); end
            checks++; if (obs_we !== st) begin errors++; $display("FAIL rnd%0d we got %b expected %b", n, obs_we, st); end
            checks++; if (obs_wstrb !== (st ? model_strobe(len, addr) : 4'b0000)) begin
               errors++; $display("FAIL rnd%0d wstrb got %b expected %b", n, obs_wstrb, st ? model_strobe(len, addr) : 4'b0000);
            end
            if (st) begin
               checks++; if (obs_wdata !== model_wdata(len, wd)) begin errors++; $display("FAIL rnd%0d wdata got %h expected %h", n, obs_wdata, model_wdata(len, wd)); end
            end
            checks++; if ({obs_stable, obs_late_bus} !== 2'b10) begin errors++; $display("FAIL rnd%0d bus_hold got %b expected 10", n, {obs_stable, obs_late_bus}); end
         end
      end
   endtask

   initial begin
      rst_n = 0; req_valid = 0; req_load = 0; req_store = 0; req_len = 2'd0; req_sign = 0;
      req_addr = '0; req_wdata = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
      exp_last = '0;
      test_reset();
      test_word_store();
      test_byte_store();
      test_load_byte();
      test_load_half();
      test_misaligned();
      test_noop_and_both();
      test_reset_mid_txn();
      test_random_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side counterpart of the instruction decoder's memory control outputs: consumes load, store, length and sign requests and executes them on a word-wide data-memory bus.
- Produces byte strobes and lane-replicated write data for stores.
- Performs lane extraction and sign or zero extension for loads.
- Sits between the execute stage and data memory; returns one response per accepted request.

Parameters:
ADDR_W, 32, byte address width of the request and memory buses.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit idle, request accepted when req_valid & req_ready
req_load  input  1  load request (decoder L)
req_store  input  1  store request (decoder wmem)
req_len  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
req_sign  input  1  sign-extend load result
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data
rsp_misalign  output  1  misaligned-access flag, valid with rsp_valid
mem_valid  output  1  bus request
mem_ready  input  1  bus accepts request
mem_we  output  1  write
mem_addr  output  ADDR_W  word-aligned address, bits [1:0] = 0
mem_wstrb  output  4  byte enables
mem_wdata  output  32  lane-replicated write data
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word

Behaviour:
- Reset (async, rst_n low, including mid-transaction):
  - state IDLE; mem_valid, mem_we, mem_wstrb, rsp_valid, rsp_misalign = 0; rsp_rdata = 0; mem_addr and mem_wdata = 0.
  - Any outstanding bus transaction is abandoned.
- FSM states: IDLE, ADDR, WAIT_R, RESP.
- req_ready = (state == IDLE), combinational.
- IDLE, on accept: all request fields latched.
  - req_load & req_store: treated as store.
  - Neither set: go to RESP, no bus access, rsp_rdata = 0.
  - Otherwise: go to ADDR.
- ADDR: mem_valid = 1; mem_addr, mem_we, mem_wstrb, mem_wdata held stable until mem_ready.
  - Store, on mem_ready: go to RESP.
  - Load, on mem_ready: go to WAIT_R. If mem_rvalid is also high that cycle, capture data and go to RESP.
  - mem_rvalid while mem_ready is low: ignored.
- WAIT_R: mem_valid = 0; wait indefinitely; on mem_rvalid, capture extracted data and go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
  - rsp_rdata holds its value until the next load response.
  - Stores leave rsp_rdata unchanged.
- Minimum latency (accept at cycle 0):
  - Store, mem_ready already high: mem_valid in cycle 1, rsp_valid in cycle 2.
  - Load, same-cycle rvalid: rsp_valid in cycle 2.
- Store encoding, a = addr[1:0]:
  - Byte: wstrb = 4'b0001 << a; wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 4'b0011 << {a[1],0}; wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'b1111.
  - Loads drive wstrb = 0.
- Load extraction:
  - Byte lane = mem_rdata >> (8*a), low 8 bits.
  - Half lane = mem_rdata >> (16*a[1]), low 16 bits.
  - Extend with the lane MSB if req_sign, else with zeros.
  - Word: no extension.
- Misaligned: half with a[0] = 1, or word with a != 0.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - A misaligned request goes IDLE -> RESP with no bus access.
  - rsp_valid = 1, rsp_misalign = 1, rsp_rdata unchanged.
  - Aligned requests report rsp_misalign = 0.
- Undefined:
  - rsp_misalign is tied to 0.
  - Misaligned low address bits are forced aligned: half uses {a[1],0}, word uses 00.
  - The aligned containing access is performed normally.

Test Plan:
- Word store: addr 0x104, wdata 0xDEADBEEF, mem_ready = 1 -> mem_addr 0x104, wstrb 1111, wdata 0xDEADBEEF, mem_we = 1; rsp_valid 2 cycles after accept.
- Byte store: addr 0x23, wdata 0x000000A5 -> wstrb 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x20.
- Load byte: addr 0x11, mem_rdata 0x12348056, mem_rvalid 3 cycles after handshake -> LB gives 0xFFFFFF80, LBU gives 0x00000080; rsp_valid exactly one cycle.
- Load half: addr 0x2, mem_rdata 0x9ABC0000 -> LH 0xFFFF9ABC, LHU 0x00009ABC; mem_ready stalled 4 cycles with mem_valid and mem_addr held stable.
- Misaligned LW at addr 0x6 -> with macro: no mem_valid, rsp_misalign = 1 in cycle 1; without macro: mem_addr 0x4, rsp_misalign = 0.
- rst_n low while in WAIT_R -> outputs return to reset values, req_ready = 1; a later mem_rvalid produces no response.
